pulse_flash_driver: RTL and testbench

//  Turns single-cycle event pulses from the button edge detector into visible LED flashes.
//  It does the reverse of edge detection: each pulse is converted back into a timed level
//  on the LED pins.
//  - Pulses are counted per channel. Flashes are served round-robin, one flash per counted pulse.
//  - Sits between the edge detector outputs and PMOD LED pins in the chip top.

---
 rtl/chip_pkg.sv | 6 +
 rtl/flash_timer.sv | 31 +++
 rtl/pulse_flash_driver.sv | 82 ++++++++
 tb/tb_pulse_flash_driver.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/chip_pkg.sv
// chip_pkg: shared FSM state encoding and LED flash patterns
package chip_pkg;
    typedef enum logic [1:0] {IDLE, ON, OFF} state_e;
    localparam logic [3:0] LED_CH0 = 4'b0011;
    localparam logic [3:0] LED_CH1 = 4'b1100;
endpackage

// File: rtl/flash_timer.sv
// flash_timer: tick prescaler plus duration counter, restarted by start; done marks the last cycle
module flash_timer #(
    parameter int TICK_DIV = 100_000,
    parameter int DUR_W    = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DUR_W-1:0] len_ticks,
    output logic             done
);
    localparam int TW = $clog2(TICK_DIV);
    logic [TW-1:0] tick_q, tick_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic wrap;
    always_comb begin
        wrap   = tick_q == TW'(TICK_DIV - 1);
        done   = wrap && dur_q == len_ticks - DUR_W'(1);
        tick_d = (start || wrap) ? '0 : tick_q + TW'(1);
        dur_d  = start ? '0 : wrap ? dur_q + DUR_W'(1) : dur_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
            dur_q  <= '0;
        end else begin
            tick_q <= tick_d;
            dur_q  <= dur_d;
        end
    end
endmodule

// File: rtl/pulse_flash_driver.sv
// pulse_flash_driver: counts per-channel event pulses and serves them round-robin as timed LED flashes
module pulse_flash_driver
    import chip_pkg::*;
#(
    parameter int TICK_DIV  = 100_000,
    parameter int ON_TICKS  = 100,
    parameter int OFF_TICKS = 100,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] pulse_in,
    output logic [3:0] led,
    output logic       busy,
    output logic       overflow
);
    localparam int MAX_T = ON_TICKS > OFF_TICKS ? ON_TICKS : OFF_TICKS;
    localparam int DUR_W = $clog2(MAX_T + 1);
    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [3:0] led_q, led_d;
    logic last_q, last_d, ovf_q, ovf_d, busy_q, busy_d;
    logic launch, pick, any_pend, done, start, dec;
    logic [DUR_W-1:0] len_ticks;
    flash_timer #(.TICK_DIV(TICK_DIV), .DUR_W(DUR_W)) u_timer (
        .clk(clk), .rst(rst), .start(start), .len_ticks(len_ticks), .done(done)
    );
    always_comb begin
        len_ticks = state_q == ON ? DUR_W'(ON_TICKS) : DUR_W'(OFF_TICKS);
        any_pend  = cnt_q[0] != '0 || cnt_q[1] != '0;
        pick      = cnt_q[~last_q] != '0 ? ~last_q : last_q;
        launch    = 1'b0;
        state_d   = state_q;
        case (state_q)
            IDLE: launch = any_pend;
            ON:   state_d = done ? OFF : ON;
            OFF: begin
                launch  = done && any_pend;
                state_d = done ? IDLE : OFF;
            end
            default: state_d = IDLE;
        endcase
        state_d = launch ? ON : state_d;
        last_d  = launch ? pick : last_q;
        start   = state_d != state_q;
        led_d   = state_d == ON ? (last_d ? LED_CH1 : LED_CH0) : 4'b0000;
        busy_d  = state_d != IDLE;
        ovf_d   = ovf_q;
        dec     = 1'b0;
        for (int i = 0; i < 2; i++) begin
            dec      = launch && pick == 1'(i);
            cnt_d[i] = cnt_q[i];
            if (pulse_in[i] && !dec) begin
                if (&cnt_q[i]) ovf_d = 1'b1;
                else cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!pulse_in[i] && dec) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '{default: '0};
            last_q  <= 1'b1;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            led_q   <= led_d;
        end
    end
    assign led      = led_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_pulse_flash_driver.sv
// tb_pulse_flash_driver: randomized and directed scoreboard bench against a behavioural flash model
module tb_pulse_flash_driver;
    localparam int ON_CYC  = 8;
    localparam int OFF_CYC = 4;
    localparam int CMAX    = 15;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] pulse_in = 2'b00;
    logic [3:0] led;
    logic busy, overflow;
    int checks = 0;
    int failures = 0;
    int m_pend[2];
    int m_mode = 0;
    int m_left = 0;
    int m_last = 1;
    bit m_ovf = 1'b0;
    int exp_q[$];
    bit run = 1'b0;
    int flashes = 0;
    int mark;
    always #5 clk = ~clk;
    pulse_flash_driver #(.TICK_DIV(4), .ON_TICKS(2), .OFF_TICKS(1), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .led(led), .busy(busy), .overflow(overflow)
    );
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic model_launch(input int b2b);
        int ch;
        ch = m_pend[1-m_last] > 0 ? 1 - m_last : m_last;
        m_pend[ch]--;
        m_last = ch;
        m_mode = 1;
        m_left = ON_CYC;
        exp_q.push_back(ch + 2 * b2b);
    endtask
    task automatic model_edge(input logic [1:0] p, input logic r);
        if (r) begin
            m_pend = '{0, 0};
            m_mode = 0;
            m_left = 0;
            m_last = 1;
            m_ovf  = 1'b0;
            exp_q.delete();
        end else begin
            if (m_mode == 0) begin
                if (m_pend[0] + m_pend[1] > 0) model_launch(0);
            end else if (m_mode == 1) begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 2;
                    m_left = OFF_CYC;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    if (m_pend[0] + m_pend[1] > 0) model_launch(1);
                    else m_mode = 0;
                end
            end
            for (int i = 0; i < 2; i++)
                if (p[i]) begin
                    if (m_pend[i] == CMAX) m_ovf = 1'b1;
                    else m_pend[i]++;
                end
        end
    endtask
    task automatic step(input logic [1:0] p, input logic r);
        @(negedge clk);
        pulse_in = p;
        rst = r;
        @(posedge clk);
        model_edge(p, r);
        #1;
    endtask
    task automatic drain(input string name);
        int n;
        n = 0;
        repeat (2) step(2'b00, 1'b0);
        while ((busy || m_mode != 0) && n < 400) begin
            step(2'b00, 1'b0);
            n++;
        end
        check({name, " idle"}, int'(busy), 0);
        check({name, " queue"}, exp_q.size(), 0);
    endtask
    initial begin
        int on_len, gap, e, pat;
        bit in_flash, prev_valid;
        on_len = 0; gap = 0; pat = 0; in_flash = 1'b0; prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (run) begin
                if (rst) begin
                    check("rst led", int'(led), 0);
                    check("rst busy", int'(busy), 0);
                    check("rst overflow", int'(overflow), 0);
                    in_flash = 1'b0;
                    prev_valid = 1'b0;
                end else begin
                    check("busy", int'(busy), int'(m_mode != 0));
                    check("overflow", int'(overflow), int'(m_ovf));
                    if (led != 4'b0000) begin
                        if (!in_flash) begin
                            flashes++;
                            in_flash = 1'b1;
                            on_len = 1;
                            if (exp_q.size() == 0) begin
                                check("unexpected flash", int'(led), 0);
                                pat = int'(led);
                            end else begin
                                e = exp_q.pop_front();
                                pat = (e % 2) != 0 ? 12 : 3;
                                check("flash pattern", int'(led), pat);
                                if (e / 2 != 0 && prev_valid) check("flash gap", gap, OFF_CYC);
                            end
                        end else begin
                            on_len++;
                            check("flash steady", int'(led), pat);
                        end
                    end else if (in_flash) begin
                        check("on length", on_len, ON_CYC);
                        in_flash = 1'b0;
                        prev_valid = 1'b1;
                        gap = 1;
                    end else begin
                        gap++;
                    end
                end
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
    initial begin
        run = 1'b1;
        repeat (2) step(2'b00, 1'b1);
        mark = flashes;
        step(2'b01, 1'b0);
        drain("s1");
        check("s1 flashes", flashes - mark, 1);
        step(2'b00, 1'b1);
        mark = flashes;
        step(2'b11, 1'b0);
        drain("s2");
        check("s2 flashes", flashes - mark, 2);
        mark = flashes;
        step(2'b10, 1'b0);
        repeat (2) step(2'b00, 1'b0);
        repeat (3) begin
            step(2'b10, 1'b0);
            step(2'b00, 1'b0);
        end
        drain("s3");
        check("s3 flashes", flashes - mark, 4);
        mark = flashes;
        step(2'b01, 1'b0);
        step(2'b01, 1'b0);
        drain("s6");
        check("s6 flashes", flashes - mark, 2);
        repeat (18) step(2'b01, 1'b0);
        check("s4 overflow set", int'(overflow), 1);
        drain("s4");
        check("s4 overflow sticky", int'(overflow), 1);
        repeat (3) step(2'b01, 1'b0);
        repeat (2) step(2'b00, 1'b0);
        check("s5 mid on", int'(led), 3);
        step(2'b00, 1'b1);
        mark = flashes;
        repeat (30) step(2'b00, 1'b0);
        check("s5 no flash", flashes - mark, 0);
        check("s5 overflow", int'(overflow), 0);
        repeat (400) step($urandom_range(0, 23) == 0 ? 2'($urandom_range(1, 3)) : 2'b00, 1'b0);
        drain("rand");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
